// File: rtl/a2bus_drive_arbiter_if.sv
// Bus-side signals of the Apple II data-bus drive arbiter: phase strobes,
// requester claims/data in, grant and transceiver controls out.
interface a2bus_drive_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic                   phi0_posedge_i;
  logic                   phi0_negedge_i;
  logic                   rw_n_i;
  logic [NUM_REQ-1:0]     req_i;
  logic [8*NUM_REQ-1:0]   req_data_i;
  logic [NUM_REQ-1:0]     grant_o;
  logic [7:0]             a2_d_o;
  logic                   a2_d_oe_o;
  logic                   conflict_o;
  logic [7:0]             conflict_count_o;

  modport master (
    output phi0_posedge_i, phi0_negedge_i, rw_n_i, req_i, req_data_i,
    input  grant_o, a2_d_o, a2_d_oe_o, conflict_o, conflict_count_o
  );

  modport slave (
    input  phi0_posedge_i, phi0_negedge_i, rw_n_i, req_i, req_data_i,
    output grant_o, a2_d_o, a2_d_oe_o, conflict_o, conflict_count_o
  );
endinterface

// File: rtl/a2bus_drive_arbiter.sv
// Round-robin arbiter for the Apple II data-bus driver: grants one slot
// requester per CPU read cycle and sequences the output enable within Phi0.
module a2bus_drive_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned OE_DELAY = 3,
  parameter int unsigned OE_HOLD  = 2
) (
  input  logic                 clk_logic_i,
  input  logic                 system_reset_i,
  a2bus_drive_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE, HOLD} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         a2_d_q;
  logic               oe_q;
  logic               conflict_q;
  logic [7:0]         count_q;

  logic [2*NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0]   win_oh;
  logic [PTR_W-1:0]     win_next;
  logic [7:0]           win_data;
  logic [7:0]           sel_data;
  logic                 found;
  int unsigned          w;

  // Rotating the doubled claim vector by the pointer turns the wrap-around
  // search into a plain lowest-set-bit search.
  always_comb begin
    rot      = {bus.req_i, bus.req_i} >> ptr_q;
    found    = 1'b0;
    w        = 0;
    win_oh   = '0;
    win_next = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        w     = (32'(ptr_q) + i) % NUM_REQ;
      end
    end
    if (found) begin
      win_oh   = NUM_REQ'(1) << w;
      win_next = PTR_W'((w + 1) % NUM_REQ);
      win_data = 8'(bus.req_data_i >> (8 * w));
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) sel_data = sel_data | bus.req_data_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      a2_d_q     <= '0;
      oe_q       <= 1'b0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      conflict_q <= 1'b0;
      if (bus.phi0_posedge_i) begin
        if (bus.rw_n_i && (bus.req_i != '0)) begin
          grant_q <= win_oh;
          ptr_q   <= win_next;
          a2_d_q  <= win_data;
          cnt_q   <= 4'(OE_DELAY);
          if (OE_DELAY == 0) begin
            state_q <= DRIVE;
            oe_q    <= 1'b1;
          end else begin
            state_q <= WAIT;
            oe_q    <= 1'b0;
          end
          if ($countones(bus.req_i) > 1) begin
            conflict_q <= 1'b1;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
          end
        end else begin
          state_q <= IDLE;
          grant_q <= '0;
          oe_q    <= 1'b0;
        end
      end else begin
        case (state_q)
          WAIT: begin
            a2_d_q <= sel_data;
            if (bus.phi0_negedge_i) begin
              state_q <= IDLE;
              grant_q <= '0;
            end else if (cnt_q == 4'd1) begin
              state_q <= DRIVE;
              oe_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          DRIVE: begin
            a2_d_q <= sel_data;
            if (bus.phi0_negedge_i) begin
              if (OE_HOLD == 0) begin
                state_q <= IDLE;
                grant_q <= '0;
                oe_q    <= 1'b0;
              end else begin
                state_q <= HOLD;
                cnt_q   <= 4'(OE_HOLD);
              end
            end
          end
          HOLD: begin
            if (cnt_q == 4'd1) begin
              state_q <= IDLE;
              grant_q <= '0;
              oe_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.grant_o          = grant_q;
  assign bus.a2_d_o           = a2_d_q;
  assign bus.a2_d_oe_o        = oe_q;
  assign bus.conflict_o       = conflict_q;
  assign bus.conflict_count_o = count_q;
endmodule

// File: tb/tb_a2bus_drive_arbiter.sv
// Bench for a2bus_drive_arbiter: three parameterisations share one stimulus
// stream and are checked every cycle against a bus-cycle timeline model.
module tb_a2bus_drive_arbiter;
  localparam int NR  = 4;
  localparam int NI  = 3;
  localparam int HN  = 16384;
  localparam int INF = 32'h3FFF_FFFF;

  int DLY [NI] = '{3, 10, 0};
  int HLD [NI] = '{2, 5, 0};

  logic clk = 1'b0;
  logic rst, pos, neg, rw;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] rdata;
  bit rnd_data;

  always #5 clk = ~clk;

  a2bus_drive_arbiter_if #(.NUM_REQ(NR)) bus0 ();
  a2bus_drive_arbiter_if #(.NUM_REQ(NR)) bus1 ();
  a2bus_drive_arbiter_if #(.NUM_REQ(NR)) bus2 ();

  a2bus_drive_arbiter #(.NUM_REQ(NR), .OE_DELAY(3),  .OE_HOLD(2)) u0 (
    .clk_logic_i(clk), .system_reset_i(rst), .bus(bus0));
  a2bus_drive_arbiter #(.NUM_REQ(NR), .OE_DELAY(10), .OE_HOLD(5)) u1 (
    .clk_logic_i(clk), .system_reset_i(rst), .bus(bus1));
  a2bus_drive_arbiter #(.NUM_REQ(NR), .OE_DELAY(0),  .OE_HOLD(0)) u2 (
    .clk_logic_i(clk), .system_reset_i(rst), .bus(bus2));

  assign bus0.phi0_posedge_i = pos; assign bus1.phi0_posedge_i = pos; assign bus2.phi0_posedge_i = pos;
  assign bus0.phi0_negedge_i = neg; assign bus1.phi0_negedge_i = neg; assign bus2.phi0_negedge_i = neg;
  assign bus0.rw_n_i = rw;          assign bus1.rw_n_i = rw;          assign bus2.rw_n_i = rw;
  assign bus0.req_i = req;          assign bus1.req_i = req;          assign bus2.req_i = req;
  assign bus0.req_data_i = rdata;   assign bus1.req_data_i = rdata;   assign bus2.req_data_i = rdata;

  logic [NR-1:0] g_o  [NI];
  logic [7:0]    d_o  [NI];
  logic          oe_o [NI];
  logic          cf_o [NI];
  logic [7:0]    cc_o [NI];
  assign g_o[0] = bus0.grant_o;  assign g_o[1] = bus1.grant_o;  assign g_o[2] = bus2.grant_o;
  assign d_o[0] = bus0.a2_d_o;   assign d_o[1] = bus1.a2_d_o;   assign d_o[2] = bus2.a2_d_o;
  assign oe_o[0] = bus0.a2_d_oe_o; assign oe_o[1] = bus1.a2_d_oe_o; assign oe_o[2] = bus2.a2_d_oe_o;
  assign cf_o[0] = bus0.conflict_o; assign cf_o[1] = bus1.conflict_o; assign cf_o[2] = bus2.conflict_o;
  assign cc_o[0] = bus0.conflict_count_o; assign cc_o[1] = bus1.conflict_count_o; assign cc_o[2] = bus2.conflict_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [8*NR-1:0] hist [HN];

  // Timeline model: each granted bus cycle is described by when it was
  // arbitrated, when its negedge came, and the first cycle it is over.
  int  arb_t [NI];
  int  win   [NI];
  int  neg_t [NI];
  int  end_t [NI];
  bit  active[NI];
  int  ptr   [NI];
  int  ccnt  [NI];
  bit  conf  [NI];
  bit  rsted [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int k, input int c);
    int w;
    conf[k]  = 1'b0;
    rsted[k] = 1'b0;
    if (rst) begin
      active[k] = 1'b0; ptr[k] = 0; ccnt[k] = 0; rsted[k] = 1'b1;
    end else if (pos) begin
      if (rw && req != 0) begin
        w = -1;
        for (int i = 0; i < NR; i++)
          if (w < 0 && req[(ptr[k] + i) % NR]) w = (ptr[k] + i) % NR;
        win[k] = w; ptr[k] = (w + 1) % NR;
        arb_t[k] = c; neg_t[k] = -1; end_t[k] = INF; active[k] = 1'b1;
        if ($countones(req) > 1) begin
          conf[k] = 1'b1;
          if (ccnt[k] < 255) ccnt[k]++;
        end
      end else if (end_t[k] > c + 1) begin
        end_t[k] = c + 1;
      end
    end else if (neg && active[k] && c > arb_t[k] && c < end_t[k] && neg_t[k] < 0) begin
      neg_t[k] = c;
      end_t[k] = (c < arb_t[k] + 1 + DLY[k]) ? c + 1 : c + HLD[k] + 1;
    end
  endtask

  task automatic compare(input int k, input int e);
    bit in_c, exp_oe;
    int idx;
    logic [8*NR-1:0] h;
    in_c   = active[k] && e > arb_t[k] && e < end_t[k];
    exp_oe = in_c && (e >= arb_t[k] + 1 + DLY[k]);
    check($sformatf("u%0d.grant", k), 32'(g_o[k]), in_c ? (32'd1 << win[k]) : 32'd0);
    check($sformatf("u%0d.oe", k), 32'(oe_o[k]), 32'(exp_oe));
    check($sformatf("u%0d.conflict", k), 32'(cf_o[k]), 32'(conf[k]));
    check($sformatf("u%0d.conflict_count", k), 32'(cc_o[k]), 32'(ccnt[k]));
    if (exp_oe) begin
      idx = (neg_t[k] >= 0 && e - 1 > neg_t[k]) ? neg_t[k] : e - 1;
      h = hist[idx % HN];
      check($sformatf("u%0d.data", k), 32'(d_o[k]), 32'(8'(h >> (8 * win[k]))));
    end
    if (rsted[k]) check($sformatf("u%0d.rst_data", k), 32'(d_o[k]), 32'd0);
  endtask

  task automatic tick();
    if (rnd_data) rdata = $urandom;
    hist[cyc % HN] = rdata;
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k, cyc);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) compare(k, cyc);
  endtask

  // Posedge now, negedge len cycles later, then gap idle cycles.
  task automatic bus_cycle(input logic r, input logic [NR-1:0] q, input int len, input int gap);
    pos = 1'b1; rw = r; req = q;
    tick();
    pos = 1'b0;
    repeat (len - 1) tick();
    neg = 1'b1;
    tick();
    neg = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pos = 1'b0; neg = 1'b0; rw = 1'b1; req = '0; rdata = '0; rnd_data = 1'b0;
    for (int k = 0; k < NI; k++) begin
      arb_t[k] = 0; win[k] = 0; neg_t[k] = -1; end_t[k] = 0; active[k] = 1'b0;
      ptr[k] = 0; ccnt[k] = 0; conf[k] = 1'b0; rsted[k] = 1'b0;
    end
    do_reset();
    tick();

    // Single requester, slice 2 = A5.
    rdata = 32'h00A5_0000;
    bus_cycle(1'b1, 4'b0100, 26, 6);

    // Round-robin rotation from a fresh pointer.
    do_reset();
    rnd_data = 1'b1;
    repeat (4) bus_cycle(1'b1, 4'b1111, 14, 4);

    // Write and empty cycles leave the pointer alone.
    bus_cycle(1'b0, 4'b0001, 14, 3);
    bus_cycle(1'b1, 4'b0000, 14, 3);
    bus_cycle(1'b1, 4'b1111, 14, 3);

    // Short phase, then HOLD truncated by a write posedge two cycles after negedge.
    bus_cycle(1'b1, 4'b0010, 5, 3);
    bus_cycle(1'b1, 4'b0001, 12, 1);
    bus_cycle(1'b0, 4'b0001, 4, 2);

    // Reset in the middle of DRIVE.
    pos = 1'b1; rw = 1'b1; req = 4'b1000;
    tick();
    pos = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    neg = 1'b1; tick(); neg = 1'b0;
    repeat (3) tick();

    // Conflict counter saturation.
    repeat (300) bus_cycle(1'b1, 4'b1111, 2, 0);
    repeat (3) tick();

    // Randomised bus traffic, requests wander mid-cycle.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(39) == 0) do_reset();
      pos = 1'b1; rw = ($urandom_range(3) != 0); req = NR'($urandom);
      tick();
      pos = 1'b0;
      for (int j = 0; j < int'($urandom_range(24)); j++) begin
        req = NR'($urandom);
        tick();
      end
      neg = 1'b1; tick(); neg = 1'b0;
      for (int j = 0; j < int'($urandom_range(4)); j++) tick();
    end
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
